// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC measurement queue.
package tdc_pkg;

   typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} send_st_e;

   localparam int TDC_MEAS_W = 40;
   localparam int TDC_SEQ_W  = 8;

   // Index of the first set bit of req[n-1:0] at or after start, wrapping; -1 if none.
   function automatic int rr_first(input logic [31:0] req, input int n, input int start);
      int idx;
      rr_first = -1;
      for (int k = 31; k >= 0; k--) begin
         if (k < n) begin
            idx = (start + k) % n;
            if (req[idx[4:0]]) rr_first = idx;
         end
      end
   endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// Single-clock FIFO with occupancy count; head is read straight from the storage flops.
module tdc_sync_fifo
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int LVL_W = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;

   // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         if (push) mem_q[wr_ptr_q] <= din;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign level = level_q;
   assign full  = (level_q == LVL_W'(DEPTH));
   assign empty = (level_q == '0);

endmodule

// File: rtl/tdc_meas_queue.sv
// Multi-channel TDC measurement queue: hold regs, round-robin arbiter, FIFO and UART send FSM.
// Define TDC_QUEUE_SEQ_EN to prepend an 8-bit push sequence number to every entry.
module tdc_meas_queue
   import tdc_pkg::*;
#(
   parameter  int N_CH   = 4,
   parameter  int MEAS_W = TDC_MEAS_W,
   parameter  int DEPTH  = 16,
   parameter  int DROP_W = 16,
   localparam int CH_W   = $clog2(N_CH),
`ifdef TDC_QUEUE_SEQ_EN
   localparam int OUT_W  = TDC_SEQ_W + CH_W + MEAS_W,
`else
   localparam int OUT_W  = CH_W + MEAS_W,
`endif
   localparam int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_CH*MEAS_W-1:0] meas_in,
   input  logic [N_CH-1:0]        meas_valid,
   input  logic                   uart_busy,
   output logic [OUT_W-1:0]       out_data,
   output logic                   out_valid,
   output logic [LVL_W-1:0]       fifo_level,
   output logic                   fifo_full,
   output logic [DROP_W-1:0]      drop_count
);

   logic [N_CH-1:0][MEAS_W-1:0] hold_q, hold_d;
   logic [N_CH-1:0]             hold_v_q, hold_v_d;
   logic [CH_W-1:0]             rr_ptr_q, rr_ptr_d, sel_ch;
   logic [DROP_W-1:0]           drop_q, drop_d;
   logic [DROP_W:0]             drop_sum;
   send_st_e                    state_q, state_d;
   logic                        out_valid_q, out_valid_d;
   logic [OUT_W-1:0]            out_data_q, out_data_d, push_data, fifo_head;
   logic                        push, pop, fifo_empty;
   int                          sel, n_drop;
`ifdef TDC_QUEUE_SEQ_EN
   logic [TDC_SEQ_W-1:0]        seq_q, seq_d;
`endif

   always_comb begin
      sel      = rr_first(32'(hold_v_q), N_CH, int'(rr_ptr_q));
      push     = !fifo_full && (sel >= 0);
      sel_ch   = push ? CH_W'(sel) : '0;
      rr_ptr_d = push ? CH_W'((sel + 1) % N_CH) : rr_ptr_q;
      hold_d   = hold_q;
      hold_v_d = hold_v_q;
      n_drop   = 0;
      if (push) hold_v_d[sel_ch] = 1'b0;
      // Clearing the drained slot first lets a same-cycle strobe land without a drop.
      for (int i = 0; i < N_CH; i++) begin
         if (meas_valid[i]) begin
            if (hold_v_d[i]) begin
               n_drop = n_drop + 1;
            end else begin
               hold_d[i]   = meas_in[i*MEAS_W +: MEAS_W];
               hold_v_d[i] = 1'b1;
            end
         end
      end
      drop_sum = {1'b0, drop_q} + (DROP_W+1)'(n_drop);
      drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
`ifdef TDC_QUEUE_SEQ_EN
      seq_d     = seq_q + TDC_SEQ_W'(push);
      push_data = {seq_q, sel_ch, hold_q[sel_ch]};
`else
      push_data = {sel_ch, hold_q[sel_ch]};
`endif
   end

   // out_data is loaded together with the pulse so the UART samples a stable word.
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      case (state_q)
         IDLE: if (!fifo_empty && !uart_busy) begin
            state_d     = SEND;
            out_valid_d = 1'b1;
            out_data_d  = fifo_head;
         end
         SEND: begin
            pop     = 1'b1;
            state_d = WAIT_ACK;
         end
         WAIT_ACK:  if (uart_busy)  state_d = WAIT_DONE;
         WAIT_DONE: if (!uart_busy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q      <= '0;
         hold_v_q    <= '0;
         rr_ptr_q    <= '0;
         drop_q      <= '0;
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef TDC_QUEUE_SEQ_EN
         seq_q       <= '0;
`endif
      end else begin
         hold_q      <= hold_d;
         hold_v_q    <= hold_v_d;
         rr_ptr_q    <= rr_ptr_d;
         drop_q      <= drop_d;
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
`ifdef TDC_QUEUE_SEQ_EN
         seq_q       <= seq_d;
`endif
      end
   end

   tdc_sync_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_data),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_tdc_meas_queue.sv
// Directed bench for tdc_meas_queue: vector table for arbitration order plus corner-case sequences.
module tb_tdc_meas_queue;

   localparam int N_CH = 4, MEAS_W = 40, DEPTH = 16, DROP_W = 4;
`ifdef TDC_QUEUE_SEQ_EN
   localparam int OUT_W = 8 + 2 + MEAS_W;
`else
   localparam int OUT_W = 2 + MEAS_W;
`endif

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N_CH*MEAS_W-1:0] meas_in;
   logic [N_CH-1:0]        meas_valid;
   logic                   uart_busy, busy_force, busy_auto;
   logic [OUT_W-1:0]       out_data;
   logic                   out_valid;
   logic [4:0]             fifo_level;
   logic                   fifo_full;
   logic [DROP_W-1:0]      drop_count;

   logic [OUT_W-1:0] got_q [$];
   int n_chk = 0, n_err = 0;

   assign uart_busy = busy_force | busy_auto;
   always #5 clk = ~clk;

   tdc_meas_queue #(.N_CH(N_CH), .MEAS_W(MEAS_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .clk(clk), .rst(rst), .meas_in(meas_in), .meas_valid(meas_valid), .uart_busy(uart_busy),
      .out_data(out_data), .out_valid(out_valid), .fifo_level(fifo_level),
      .fifo_full(fifo_full), .drop_count(drop_count)
   );

   // UART model: record each pulse, raise busy a cycle later, hold it for three cycles.
   initial begin
      busy_auto = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (out_valid) begin
            got_q.push_back(out_data);
            busy_auto = 1'b1;
            repeat (3) @(posedge clk);
            #1 busy_auto = 1'b0;
         end
      end
   end

   typedef struct {
      logic [3:0]       m;
      logic [3:0][39:0] v;
      int               n;
      logic [3:0][41:0] e;
   } vec_t;
   vec_t tbl [6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic [3:0] m, input logic [3:0][39:0] v);
      meas_valid = m;
      meas_in    = v;
      @(negedge clk);
      meas_valid = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_got(input int n, input int budget);
      int c = 0;
      while (got_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("sent_count", 64'(got_q.size()), 64'(n));
   endtask

   function automatic logic [63:0] got42(input int j);
      logic [OUT_W-1:0] w;
      if (j >= got_q.size()) return '1;
      w = got_q[j];
      return 64'(w[41:0]);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      meas_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int lat;
      busy_force = 1'b0;
      meas_in = '0;
      tbl[0].m = 4'b1111; tbl[0].v = {40'd4, 40'd3, 40'd2, 40'd1}; tbl[0].n = 4;
      tbl[0].e = {{2'd3, 40'd4}, {2'd2, 40'd3}, {2'd1, 40'd2}, {2'd0, 40'd1}};
      tbl[1].m = 4'b0001; tbl[1].v = {40'd0, 40'd0, 40'd0, 40'h12_3456_789A}; tbl[1].n = 1;
      tbl[1].e = {42'd0, 42'd0, 42'd0, {2'd0, 40'h12_3456_789A}};
      tbl[2].m = 4'b1010; tbl[2].v = {40'hA3, 40'd0, 40'hA1, 40'd0}; tbl[2].n = 2;
      tbl[2].e = {42'd0, 42'd0, {2'd3, 40'hA3}, {2'd1, 40'hA1}};
      tbl[3].m = 4'b0101; tbl[3].v = {40'd0, 40'hB2, 40'd0, 40'hB0}; tbl[3].n = 2;
      tbl[3].e = {42'd0, 42'd0, {2'd2, 40'hB2}, {2'd0, 40'hB0}};
      tbl[4].m = 4'b1001; tbl[4].v = {40'hC3, 40'd0, 40'd0, 40'hC0}; tbl[4].n = 2;
      tbl[4].e = {42'd0, 42'd0, {2'd0, 40'hC0}, {2'd3, 40'hC3}};
      tbl[5].m = 4'b0110; tbl[5].v = {40'd0, 40'hD2, 40'hD1, 40'd0}; tbl[5].n = 2;
      tbl[5].e = {42'd0, 42'd0, {2'd2, 40'hD2}, {2'd1, 40'hD1}};

      @(negedge clk);
      do_reset();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_full", 64'(fifo_full), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);

      // Round-robin order across bursts; rr pointer carries over between rows.
      for (int r = 0; r < 6; r++) begin
         got_q.delete();
         cyc(tbl[r].m, tbl[r].v);
         wait_got(tbl[r].n, 300);
         for (int j = 0; j < tbl[r].n; j++) chk($sformatf("vec%0d_out%0d", r, j), got42(j), 64'(tbl[r].e[j]));
         idle(10);
         chk($sformatf("vec%0d_extra", r), 64'(got_q.size()), 64'(tbl[r].n));
         chk($sformatf("vec%0d_level", r), 64'(fifo_level), 64'd0);
         chk($sformatf("vec%0d_drop", r), 64'(drop_count), 64'd0);
      end

      // Uncontended latency: strobe -> out_valid three cycles later, one cycle wide.
      got_q.delete();
      meas_valid = 4'b0001;
      meas_in    = {40'd0, 40'd0, 40'd0, 40'hE0};
      @(negedge clk);
      meas_valid = '0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 64'(lat), 64'd3);
      chk("lat_data", 64'(out_data[41:0]), 64'({2'd0, 40'hE0}));
      @(negedge clk);
      chk("pulse_width", 64'(out_valid), 64'd0);
      idle(10);

      // Strobe on the drain cycle of the same channel is captured, not dropped.
      got_q.delete();
      cyc(4'b0100, {40'd0, 40'hE1, 40'd0, 40'd0});
      cyc(4'b0100, {40'd0, 40'hE2, 40'd0, 40'd0});
      wait_got(2, 300);
      chk("drain_cap0", got42(0), 64'({2'd2, 40'hE1}));
      chk("drain_cap1", got42(1), 64'({2'd2, 40'hE2}));
      chk("drain_cap_drop", 64'(drop_count), 64'd0);
      idle(10);

      // Backpressure: 16 in FIFO, 1 held, 3 dropped, then all 17 drained in order.
      got_q.delete();
      busy_force = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cyc(4'b0010, {40'd0, 40'd0, 40'(100 + k), 40'd0});
         idle(3);
      end
      chk("bp_full", 64'(fifo_full), 64'd1);
      chk("bp_level", 64'(fifo_level), 64'd16);
      chk("bp_drop", 64'(drop_count), 64'd3);
      chk("bp_no_send", 64'(got_q.size()), 64'd0);
      busy_force = 1'b0;
      wait_got(17, 2000);
      for (int k = 0; k < 17; k++) chk($sformatf("bp_out%0d", k), got42(k), 64'({2'd1, 40'(100 + k)}));
      idle(10);
      chk("bp_level_end", 64'(fifo_level), 64'd0);
      chk("bp_drop_end", 64'(drop_count), 64'd3);

      // Drop counter: increments by channels lost per cycle and saturates.
      do_reset();
      busy_force = 1'b1;
      for (int k = 0; k < 17; k++) cyc(4'b0001, {40'd0, 40'd0, 40'd0, 40'(k)});
      cyc(4'b1110, {40'd3, 40'd2, 40'd1, 40'd0});
      chk("sat_level", 64'(fifo_level), 64'd16);
      chk("sat_drop0", 64'(drop_count), 64'd0);
      cyc(4'b1111, {40'd9, 40'd9, 40'd9, 40'd9});
      chk("sat_drop4", 64'(drop_count), 64'd4);
      for (int k = 0; k < 4; k++) cyc(4'b1111, {40'd9, 40'd9, 40'd9, 40'd9});
      chk("sat_dropF", 64'(drop_count), 64'hF);
      cyc(4'b1111, {40'd9, 40'd9, 40'd9, 40'd9});
      chk("sat_stay", 64'(drop_count), 64'hF);

      // Reset during WAIT_DONE with 5 entries queued flushes everything.
      do_reset();
      chk("rst2_drop", 64'(drop_count), 64'd0);
      chk("rst2_level", 64'(fifo_level), 64'd0);
      for (int k = 0; k < 6; k++) cyc(4'b0100, {40'd0, 40'(200 + k), 40'd0, 40'd0});
      idle(3);
      got_q.delete();
      busy_force = 1'b0;
      wait_got(1, 100);
      chk("wd_first", got42(0), 64'({2'd2, 40'd200}));
      idle(2);
      chk("wd_level", 64'(fifo_level), 64'd5);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_level", 64'(fifo_level), 64'd0);
      chk("midrst_full", 64'(fifo_full), 64'd0);
      chk("midrst_drop", 64'(drop_count), 64'd0);
      rst = 1'b0;
      got_q.delete();
      idle(40);
      chk("no_stale_send", 64'(got_q.size()), 64'd0);

`ifdef TDC_QUEUE_SEQ_EN
      // Sequence number per accepted push, wrapping after 255.
      got_q.delete();
      for (int k = 0; k < 260; k++) begin
         cyc(4'b0001, {40'd0, 40'd0, 40'd0, 40'(k)});
         idle(7);
      end
      wait_got(260, 2000);
      for (int k = 0; k < 260 && k < got_q.size(); k++) begin
         chk($sformatf("seq%0d", k), 64'(got_q[k][49:42]), 64'(k % 256));
         chk($sformatf("seq_meas%0d", k), got42(k), 64'({2'd0, 40'(k)}));
      end
      chk("seq_drop", 64'(drop_count), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
